// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: multi-digit seven-segment hex display controller.
// A captured hex value is decoded to active-low segment patterns. The live
// controls lamp test, per-digit blink and leading-zero blanking sit on top
// of that decode.
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous active-high reset
//   value      4*DIGITS hex nibbles, nibble i -> digit i (digit 0 rightmost)
//   load       capture strobe for value
//   blank_lz   leading-zero suppression enable (live)
//   blink_en   per-digit blink enable (live)
//   lamp_test  force all segments on (live)
//   HEX        7*DIGITS active-low segments, digit i at [7i+6:7i], g..a
//   loaded     high once a value has been captured since reset
module hex_display_ctrl #(
   parameter int DIGITS     = 6,
   parameter int BLINK_HALF = 25000000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [4*DIGITS-1:0]   value,
   input  logic                  load,
   input  logic                  blank_lz,
   input  logic [DIGITS-1:0]     blink_en,
   input  logic                  lamp_test,
   output logic [7*DIGITS-1:0]   HEX,
   output logic                  loaded
);

   localparam int CW = $clog2(BLINK_HALF);
   localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_HALF - 1);
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   logic [4*DIGITS-1:0] value_q, value_d;
   logic                loaded_q, loaded_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                ph_q, ph_d;

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: glyph = 7'b1000000;
         4'h1: glyph = 7'b1111001;
         4'h2: glyph = 7'b0100100;
         4'h3: glyph = 7'b0110000;
         4'h4: glyph = 7'b0011001;
         4'h5: glyph = 7'b0010010;
         4'h6: glyph = 7'b0000010;
         4'h7: glyph = 7'b1111000;
         4'h8: glyph = 7'b0000000;
         4'h9: glyph = 7'b0010000;
         4'hA: glyph = 7'b0001000;
         4'hB: glyph = 7'b0000011;
         4'hC: glyph = 7'b0100111;
         4'hD: glyph = 7'b0100001;
         4'hE: glyph = 7'b0000110;
         default: glyph = 7'b0001110;
      endcase
   endfunction

   // Next state. The blink counter runs free so that toggling blink_en
   // never disturbs the phase.
   always_comb begin
      value_d  = value_q;
      loaded_d = loaded_q;
      cnt_d    = cnt_q + 1'b1;
      ph_d     = ph_q;
      if (load) begin
         value_d  = value;
         loaded_d = 1'b1;
      end
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         ph_d  = ~ph_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         value_q  <= '0;
         loaded_q <= 1'b0;
         cnt_q    <= '0;
         ph_q     <= 1'b0;
      end else begin
         value_q  <= value_d;
         loaded_q <= loaded_d;
         cnt_q    <= cnt_d;
         ph_q     <= ph_d;
      end
   end

   // Output decode. Walk from the most significant digit down so that
   // all_zero means "this nibble and every nibble above it are zero".
   logic       all_zero;
   logic [6:0] seg;

   always_comb begin
      HEX      = '1;
      all_zero = 1'b1;
      seg      = SEG_BLANK;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         all_zero = all_zero & (value_q[4*i +: 4] == 4'h0);
         if (lamp_test)
            seg = 7'b0000000;
         else if (!loaded_q)
            seg = SEG_BLANK;
         else if (blink_en[i] && ph_q)
            seg = SEG_BLANK;
         else if (blank_lz && (i != 0) && all_zero)
            seg = SEG_BLANK;
         else
            seg = glyph(value_q[4*i +: 4]);
         HEX[7*i +: 7] = seg;
      end
   end

   assign loaded = loaded_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl (DIGITS=6, BLINK_HALF=4). A cycle-level model
// tracks the captured value and the cycles elapsed since reset; the blink
// phase is derived arithmetically from that elapsed count.
module tb_hex_display_ctrl;

   localparam int D  = 6;
   localparam int BH = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic [4*D-1:0]  value;
   logic            load;
   logic            blank_lz;
   logic [D-1:0]    blink_en;
   logic            lamp_test;
   logic [7*D-1:0]  HEX;
   logic            loaded;

   hex_display_ctrl #(.DIGITS(D), .BLINK_HALF(BH)) dut (
      .clk(clk), .reset(reset), .value(value), .load(load),
      .blank_lz(blank_lz), .blink_en(blink_en), .lamp_test(lamp_test),
      .HEX(HEX), .loaded(loaded)
   );

   always #5 clk = ~clk;

   logic [6:0] GLY [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110 };

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // model state
   logic [4*D-1:0] vm;
   logic           lm;
   int             t;

   always @(posedge clk) begin
      if (reset) begin
         vm <= '0; lm <= 1'b0; t <= 0;
      end else begin
         t <= t + 1;
         if (load) begin vm <= value; lm <= 1'b1; end
      end
   end

   function automatic logic [7*D-1:0] model_hex();
      logic [7*D-1:0] h;
      logic [6:0] s;
      h = '1;
      for (int i = 0; i < D; i++) begin
         if (lamp_test)                                    s = 7'b0000000;
         else if (!lm)                                     s = 7'b1111111;
         else if (blink_en[i] && ((t / BH) % 2 == 1))      s = 7'b1111111;
         else if (blank_lz && i > 0 && (vm >> (4*i)) == 0) s = 7'b1111111;
         else                                              s = GLY[vm[4*i +: 4]];
         h[7*i +: 7] = s;
      end
      return h;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_hex", 64'(HEX), 64'(model_hex()));
         chk("model_loaded", 64'(loaded), 64'(lm));
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic chk_hex(input string nm, input logic [7*D-1:0] e, input logic el);
      @(negedge clk);
      chk({nm, "_hex"}, 64'(HEX), 64'(e));
      chk({nm, "_loaded"}, 64'(loaded), 64'(el));
   endtask

   localparam logic [6:0] BL = 7'b1111111;
   localparam logic [6:0] Z0 = 7'b1000000;

   initial begin
      reset = 1'b1; load = 1'b0; value = '0; blank_lz = 1'b0;
      blink_en = '0; lamp_test = 1'b0;
      tick(); chk_en = 1'b1; tick();

      // lamp test straight after reset, then release
      reset = 1'b0; lamp_test = 1'b1;
      chk_hex("lamp", '0, 1'b0);
      tick(); lamp_test = 1'b0;
      chk_hex("post_reset_blank", '1, 1'b0);

      // single F, without and with leading-zero blanking
      tick(); value = 24'h00000F; load = 1'b1;
      tick(); load = 1'b0;
      chk_hex("F_nolz", {{5{Z0}}, 7'b0001110}, 1'b1);
      tick(); blank_lz = 1'b1;
      chk_hex("F_lz", {{5{BL}}, 7'b0001110}, 1'b1);
      tick(); value = '0; load = 1'b1;
      tick(); load = 1'b0;
      chk_hex("zero_lz", {{5{BL}}, Z0}, 1'b1);

      // back-to-back loads with load held high; last one wins
      tick(); blank_lz = 1'b0; load = 1'b1; value = 24'h111111;
      tick(); value = 24'hABCDEF;
      tick(); value = 24'h000200; blank_lz = 1'b1;
      tick(); load = 1'b0;
      chk_hex("b2b_last", {BL, BL, BL, 7'b0100100, Z0, Z0}, 1'b1);

      // blink on digit 0 starting from a fresh phase
      tick(); reset = 1'b1;
      tick(); reset = 1'b0; blank_lz = 1'b0; value = 24'h123ABC; load = 1'b1;
      blink_en = 6'b000001;
      tick(); load = 1'b0;
      chk_hex("blink_on1",
              {7'b1111001, 7'b0100100, 7'b0110000, 7'b0001000, 7'b0000011, 7'b0100111}, 1'b1);
      repeat (3) tick();
      chk_hex("blink_off",
              {7'b1111001, 7'b0100100, 7'b0110000, 7'b0001000, 7'b0000011, BL}, 1'b1);
      repeat (4) tick();
      chk_hex("blink_on2",
              {7'b1111001, 7'b0100100, 7'b0110000, 7'b0001000, 7'b0000011, 7'b0100111}, 1'b1);
      repeat (5) tick();
      blink_en = 6'b101010;
      repeat (12) tick();

      // reset wins over a simultaneous load
      blink_en = '0; value = 24'h654321; load = 1'b1;
      tick(); load = 1'b0;
      tick(); reset = 1'b1; load = 1'b1; value = 24'hFFFFFF;
      tick(); reset = 1'b0; load = 1'b0;
      chk_hex("reset_wins", '1, 1'b0);
      tick(); blink_en = 6'h3F; load = 1'b1; value = 24'h000001;
      tick(); load = 1'b0;
      chk_hex("after_reset_load", {{5{Z0}}, 7'b1111001}, 1'b1);
      repeat (10) tick();

      // glyph sweep through digit 5
      blink_en = '0; blank_lz = 1'b0;
      for (int n = 0; n < 16; n++) begin
         tick(); value = {4'(n), 20'h0}; load = 1'b1;
         tick(); load = 1'b0;
         @(negedge clk);
         chk($sformatf("glyph_%0h", n), 64'(HEX[7*5 +: 7]), 64'(GLY[n]));
      end

      // reset mid-display blanks until the next load
      tick(); reset = 1'b1;
      tick(); reset = 1'b0;
      chk_hex("mid_reset", '1, 1'b0);
      repeat (3) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hex_display_ctrl.md
HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

Interface
REQ-001 Parameter DIGITS, default 6: number of seven-segment digits driven, legal range 1..8.
REQ-002 Parameter BLINK_HALF, default 25000000: blink half-period in clk cycles, minimum 2.
REQ-003 The port list SHALL be: clk  in  1  sole clock, all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-005 value  in  4*DIGITS  hex nibbles; nibble i (bits 4i+3:4i) feeds digit i, digit 0 rightmost.
REQ-006 load  in  1  capture strobe; value is registered on any edge where load=1.
REQ-007 blank_lz  in  1  leading-zero suppression enable, applied live (not captured).
REQ-008 blink_en  in  DIGITS  per-digit blink enable, applied live.
REQ-009 lamp_test  in  1  force all segments on, applied live.
REQ-010 HEX  out  7*DIGITS  active-low segments; digit i on bits 7i+6:7i, bit order g,f,e,d,c,b,a (6..0).
REQ-011 loaded  out  1  high once a value has been captured since reset.

Function
REQ-012 Registered state SHALL be: value_q (4*DIGITS), loaded_q, blink counter cnt, blink phase ph.
REQ-013 HEX and loaded SHALL be combinational decodes of registered state plus the live inputs blank_lz, blink_en and lamp_test, with no input-to-output path from value or load.
REQ-014 A load edge SHALL update value_q, and HEX SHALL reflect the new value in the cycle after that edge (1-cycle latency).
REQ-015 Glyphs (active-low, g..a) SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, c=0100111, d=0100001, E=0000110, F=0001110; blank=1111111.
REQ-016 Output priority, highest first: lamp_test, giving all digits 0000000; then loaded_q=0, giving all digits blank; then blink, where digit i is blank when blink_en[i]=1 and ph=1; then leading-zero suppression; then the glyph.
REQ-017 With blank_lz=1, digit i (i>=1) SHALL be blank when nibbles i..DIGITS-1 of value_q are all zero.
REQ-018 Digit 0 SHALL never be blanked by leading-zero suppression, so a value of 0 shows a single "0".
REQ-019 The cnt register SHALL increment every cycle from 0 to BLINK_HALF-1.
REQ-020 At the cnt terminal count, cnt SHALL wrap to 0 and ph SHALL toggle on the same edge.
REQ-021 cnt SHALL be ceil(log2(BLINK_HALF)) bits wide and SHALL not overflow.
REQ-022 The blink counter SHALL run free regardless of blink_en, so changes to blink_en take effect immediately without resetting the phase.
REQ-023 Back-to-back load pulses SHALL each capture, and the last captured value SHALL be displayed.
REQ-024 load held high SHALL track value with 1-cycle latency.
REQ-025 When load and reset are asserted on the same edge, reset SHALL win and value_q SHALL not be captured.

Reset
REQ-026 On a reset edge: value_q=0, loaded_q=0, cnt=0, ph=0.
REQ-027 In the cycle after a reset edge, loaded=0 and every HEX digit SHALL be 1111111 unless lamp_test=1.
REQ-028 Reset asserted mid-blink SHALL restart the blink phase at the visible half (ph=0).
REQ-029 Reset asserted mid-display SHALL blank the display until the next load.

Verification (DIGITS=6, BLINK_HALF=4)
REQ-030 Reset, load value=0x00000F, blank_lz=0 -> next cycle: HEX digit0=0001110, digits1..5=1000000, loaded=1.
REQ-031 Same value with blank_lz=1 -> digit0=0001110, digits1..5=1111111; then load 0x000000 -> digit0=1000000, digits1..5=1111111.
REQ-032 Load 0x123ABC, blink_en=6'b000001 -> digit0 (c) shows 0100111 for 4 cycles, then 1111111 for 4 cycles, repeating; other digits steady.
REQ-033 lamp_test=1 immediately after reset, before any load -> all digits 0000000; release -> all 1111111.
REQ-034 Load 0x654321, then assert reset together with load of 0xFFFFFF -> loaded=0, all digits blank, ph=0; next load of 0x000001 shows digit0=1111001.
REQ-035 Sweep each nibble 0..F through digit 5 with blank_lz=0 -> digit 5 glyphs match the REQ-015 table exactly.
